pwm_ramp_ctrl: RTL and testbench

//  - Duty-cycle sequencer that drives the duty_cycle input of the 8-bit PWM generator.
//  - Accepts ramp commands (target, step size, hold interval) over a valid/ready handshake.
//  - Walks duty toward the target one step at a time, changing it only at PWM period boundaries.
//  - Provides glitch-free soft-start, fade and soft-stop.
//  - Sits between the register/control logic and the PWM generator instance.

---
 rtl/pwm_pkg.sv | 45 ++++
 rtl/pwm_period_timer.sv | 36 +++
 rtl/pwm_ramp_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
//   Shared definitions for the PWM-side blocks:
//     - ramp controller FSM state encoding (IDLE / RAMP / DONE)
//     - default duty and hold widths
//     - sat_step(): one saturating step of duty toward a target
//   sat_step() works on a fixed CALC_W-bit operand width. Callers with a
//   narrower duty zero-extend into CALC_W bits and take the low bits of the
//   result, so any DUTY_W <= CALC_W is supported.
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam int DUTY_W_DEF = 8;
    localparam int HOLD_W_DEF = 8;
    localparam int CALC_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } ramp_state_t;

    // One step of cur toward tgt by step, never passing tgt.
    // The sum and difference carry one extra bit, so a large step can
    // neither wrap past the top of the range nor borrow below zero.
    function automatic logic [CALC_W-1:0] sat_step(
        input logic [CALC_W-1:0] cur,
        input logic [CALC_W-1:0] tgt,
        input logic [CALC_W-1:0] step
    );
        logic [CALC_W:0] sum;
        logic [CALC_W:0] diff;
        sum  = {1'b0, cur} + {1'b0, step};
        diff = {1'b0, cur} - {1'b0, step};
        if (tgt > cur) begin
            sat_step = (sum >= {1'b0, tgt}) ? tgt : sum[CALC_W-1:0];
        end else if (diff[CALC_W] || (diff[CALC_W-1:0] <= tgt)) begin
            // borrow out, or landed at/below the target: stop on the target
            sat_step = tgt;
        end else begin
            sat_step = diff[CALC_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// ---------------------------------------------------------------------------
// pwm_period_timer
//   Free-running PWM period counter shared by the PWM-side blocks so that
//   every block sees the same period boundary. It is reset by the same rst
//   as the PWM generator and therefore stays aligned with its counter.
//
//   Ports
//     clk         in   system clock, rising edge
//     rst         in   asynchronous active-high reset
//     per_cnt     out  period position, 0 .. 2**DUTY_W-1, wraps to 0
//     period_end  out  high on the last clk of each period (per_cnt all-ones)
// ---------------------------------------------------------------------------
module pwm_period_timer
    import pwm_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DUTY_W-1:0] per_cnt,
    output logic              period_end
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // Decoded straight from the counter register, so it is glitch-free and
    // low in reset (per_cnt == 0).
    assign period_end = &per_cnt;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_ramp_ctrl
//   Duty-cycle sequencer in front of the 8-bit PWM generator. It accepts
//   ramp commands (target, step, hold) and walks duty_cycle toward the target
//   one step at a time. duty_cycle only changes on the clk edge that ends a
//   period_end cycle, so a new value always takes effect from per_cnt == 0
//   and never in the middle of a PWM period (glitch-free soft-start, fade and
//   soft-stop).
//
//   Build option
//     PWM_RAMP_CLAMP_EN  when defined, an accepted target is clamped to
//                        MAX_DUTY, so duty_cycle never exceeds MAX_DUTY.
//                        When undefined the target is used as given.
//
//   Ports
//     clk         in   system clock, rising edge
//     rst         in   asynchronous active-high reset
//     cmd_valid   in   ramp command present
//     cmd_ready   out  controller can accept a command (IDLE only)
//     cmd_target  in   final duty value
//     cmd_step    in   duty change per step, 0 behaves as 1
//     cmd_hold    in   extra whole periods between steps, 0 = every period
//     abort       in   soft-stop: duty to 0 at the next period boundary
//     duty_cycle  out  duty value to the PWM generator
//     period_end  out  1-cycle strobe on the last clk of each PWM period
//     busy        out  ramp in progress
//     done        out  1-cycle pulse when duty_cycle reaches the target
//     state_dbg   out  current FSM state (pwm_pkg::ramp_state_t encoding)
//
//   Handshake: a command transfers on any clk edge where cmd_valid and
//   cmd_ready are both high. cmd_ready is high only in IDLE and drops the
//   cycle after a transfer. A command that transfers in the same cycle as an
//   abort request, or on the boundary where a pending abort is serviced, is
//   consumed and discarded (abort wins). While not ready, cmd_valid is
//   ignored and the requester must keep holding it.
// ---------------------------------------------------------------------------
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int DUTY_W   = DUTY_W_DEF,   // must not exceed pwm_pkg::CALC_W
    parameter int HOLD_W   = HOLD_W_DEF,
    parameter int MAX_DUTY = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic [DUTY_W-1:0] cmd_step,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              period_end,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    ramp_state_t       state;
    logic [DUTY_W-1:0] tgt_q;        // latched (possibly clamped) target
    logic [DUTY_W-1:0] step_q;       // latched step, never zero
    logic [HOLD_W-1:0] hold_q;       // latched hold reload value
    logic [HOLD_W-1:0] hold_cnt;     // boundaries still to skip before a step
    logic              abort_pend;   // soft-stop requested, not yet serviced

    logic [DUTY_W-1:0] per_cnt;
    logic [DUTY_W-1:0] acc_target;
    logic [DUTY_W-1:0] acc_step;
    logic [DUTY_W-1:0] next_duty;
    logic [CALC_W-1:0] cur_ext;
    logic [CALC_W-1:0] tgt_ext;
    logic [CALC_W-1:0] step_ext;
    logic [CALC_W-1:0] next_ext;
    logic              cmd_fire;
    logic              unused_bits;

    // -----------------------------------------------------------------------
    // Period boundary, shared with the PWM generator
    // -----------------------------------------------------------------------
    pwm_period_timer #(
        .DUTY_W (DUTY_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .per_cnt    (per_cnt),
        .period_end (period_end)
    );

    // -----------------------------------------------------------------------
    // Command capture values
    // -----------------------------------------------------------------------
`ifdef PWM_RAMP_CLAMP_EN
    localparam logic [DUTY_W-1:0] MAX_DUTY_C = DUTY_W'(MAX_DUTY);
    assign acc_target = (cmd_target > MAX_DUTY_C) ? MAX_DUTY_C : cmd_target;
    // The period position and the unused high bits of the wide step result
    // carry no information this block needs.
    assign unused_bits = ^{per_cnt, next_ext};
`else
    assign acc_target = cmd_target;
    // MAX_DUTY only matters in clamp builds; the period position and the
    // unused high bits of the wide step result are not needed here either.
    assign unused_bits = ^{per_cnt, next_ext} ^ (MAX_DUTY != 0);
`endif

    // A zero step would never make progress, so it is taken as 1.
    assign acc_step = (cmd_step == '0) ? DUTY_W'(1) : cmd_step;

    assign cmd_fire = cmd_valid & cmd_ready;

    // -----------------------------------------------------------------------
    // Next duty value: one saturating step from the current duty
    // -----------------------------------------------------------------------
    always_comb begin
        cur_ext  = '0;
        tgt_ext  = '0;
        step_ext = '0;
        cur_ext[DUTY_W-1:0]  = duty_cycle;
        tgt_ext[DUTY_W-1:0]  = tgt_q;
        step_ext[DUTY_W-1:0] = step_q;
        next_ext = sat_step(cur_ext, tgt_ext, step_ext);
    end

    assign next_duty = next_ext[DUTY_W-1:0];

    // -----------------------------------------------------------------------
    // Ramp FSM with registered outputs
    //   IDLE : ready for a command
    //   RAMP : step duty on period boundaries, honouring the hold interval
    //   DONE : one cycle with done high, then back to IDLE
    // A pending abort overrides every state on the next period boundary.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            duty_cycle <= '0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            abort_pend <= 1'b0;
            tgt_q      <= '0;
            step_q     <= '0;
            hold_q     <= '0;
            hold_cnt   <= '0;
        end else begin
            done <= 1'b0;

            if (abort) begin
                abort_pend <= 1'b1;
            end

            if (period_end && abort_pend) begin
                // Soft-stop. An abort raised on this same edge is satisfied
                // by this drop, so the flag is simply cleared.
                duty_cycle <= '0;
                abort_pend <= 1'b0;
                state      <= IDLE;
                cmd_ready  <= 1'b1;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_fire && !abort) begin
                            tgt_q     <= acc_target;
                            step_q    <= acc_step;
                            hold_q    <= cmd_hold;
                            hold_cnt  <= cmd_hold;
                            cmd_ready <= 1'b0;
                            if (acc_target == duty_cycle) begin
                                // Already there: complete without touching duty.
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= RAMP;
                                busy  <= 1'b1;
                            end
                        end
                    end

                    RAMP: begin
                        if (period_end) begin
                            if (hold_cnt != '0) begin
                                hold_cnt <= hold_cnt - 1'b1;
                            end else begin
                                duty_cycle <= next_duty;
                                hold_cnt   <= hold_q;
                                if (next_duty == tgt_q) begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end
                        end
                    end

                    DONE: begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end

                    default: begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwm_ramp_ctrl
//   Self-checking bench for pwm_ramp_ctrl. Expected duty sequences are built
//   from the ramp rules (min/max stepping toward the target, one change every
//   hold+1 period boundaries) into exp_q; the bench tracks the PWM period
//   position with its own counter started at reset release.
//   Honours PWM_RAMP_CLAMP_EN the same way the design does (MAX_DUTY = 180).
// ---------------------------------------------------------------------------
module tb_pwm_ramp_ctrl;

    localparam int DUTY_W   = 8;
    localparam int HOLD_W   = 8;
    localparam int MAX_DUTY = 180;
    localparam int PERIOD   = 256;

    // -----------------------------------------------------------------------
    // Clock / reset / DUT
    // -----------------------------------------------------------------------
    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DUTY_W-1:0] cmd_target;
    logic [DUTY_W-1:0] cmd_step;
    logic [HOLD_W-1:0] cmd_hold;
    logic              abort;
    logic [DUTY_W-1:0] duty_cycle;
    logic              period_end;
    logic              busy;
    logic              done;
    logic [1:0]        state_dbg;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(
        .DUTY_W   (DUTY_W),
        .HOLD_W   (HOLD_W),
        .MAX_DUTY (MAX_DUTY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_hold   (cmd_hold),
        .abort      (abort),
        .duty_cycle (duty_cycle),
        .period_end (period_end),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // -----------------------------------------------------------------------
    // Bench state
    // -----------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;
    int tb_cnt  = 0;     // expected per_cnt after the latest edge
    int m_duty  = 0;     // expected duty between scenarios
    logic [DUTY_W-1:0] exp_q[$];

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        tb_cnt = (tb_cnt + 1) % PERIOD;
    endtask

    // -----------------------------------------------------------------------
    // Generic ramp scenario: issue a command from duty m_duty and follow it
    // to completion (or to an abort issued at per_cnt 100 after abort_after
    // boundaries; -1 means no abort).
    // -----------------------------------------------------------------------
    task automatic run_ramp(input int tgt_in, input int stp, input int hold,
                            input int abort_after, input string tag);
        int tgt;
        int eff;
        int cur;
        int nb;
        int budget;
        int n;
        bit bnd;
        bit abort_req;
        bit finished;
`ifdef PWM_RAMP_CLAMP_EN
        tgt = (tgt_in > MAX_DUTY) ? MAX_DUTY : tgt_in;
`else
        tgt = tgt_in;
`endif
        eff = (stp == 0) ? 1 : stp;
        cur = m_duty;
        exp_q.delete();
        while (cur != tgt) begin
            if (tgt > cur) cur = (cur + eff >= tgt) ? tgt : cur + eff;
            else           cur = (cur - eff <= tgt) ? tgt : cur - eff;
            exp_q.push_back(DUTY_W'(cur));
        end

        n = 0;
        while (cmd_ready !== 1'b1 && n < 600) begin
            cyc();
            n++;
        end
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL %s ready_wait: cmd_ready=%b required 1", tag, cmd_ready);
        else n_pass++;

        cmd_valid  = 1'b1;
        cmd_target = DUTY_W'(tgt_in);
        cmd_step   = DUTY_W'(stp);
        cmd_hold   = HOLD_W'(hold);
        cyc();
        cmd_valid  = 1'b0;
        cmd_target = DUTY_W'($urandom);
        cmd_step   = DUTY_W'($urandom);
        cmd_hold   = HOLD_W'($urandom);

        if (exp_q.size() == 0) begin
            n_total++;
            if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b0 || duty_cycle !== DUTY_W'(m_duty))
                $display("FAIL %s equal_accept: done=%b busy=%b ready=%b duty=%0d required 1 0 0 %0d",
                         tag, done, busy, cmd_ready, duty_cycle, m_duty);
            else n_pass++;
            cyc();
            n_total++;
            if (done !== 1'b0 || cmd_ready !== 1'b1 || duty_cycle !== DUTY_W'(m_duty))
                $display("FAIL %s equal_after: done=%b ready=%b duty=%0d required 0 1 %0d",
                         tag, done, cmd_ready, duty_cycle, m_duty);
            else n_pass++;
            return;
        end

        n_total++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0)
            $display("FAIL %s accept: busy=%b ready=%b done=%b required 1 0 0", tag, busy, cmd_ready, done);
        else n_pass++;

        cur       = m_duty;
        nb        = 0;
        abort_req = 1'b0;
        finished  = 1'b0;
        budget    = PERIOD * (hold + 1) * (exp_q.size() + 1) + 2 * PERIOD;
        while (!finished && budget > 0) begin
            bnd = (tb_cnt == PERIOD - 1);
            if (abort_after >= 0 && !abort_req && nb == abort_after && tb_cnt == 100) begin
                abort     = 1'b1;
                abort_req = 1'b1;
            end
            // Commands presented mid-ramp must be ignored.
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_target = DUTY_W'($urandom);
            cyc();
            abort  = 1'b0;
            budget = budget - 1;
            if (bnd) begin
                nb++;
                if (abort_req) begin
                    cur      = 0;
                    finished = 1'b1;
                end else if (nb % (hold + 1) == 0) begin
                    cur = int'(exp_q.pop_front());
                    if (exp_q.size() == 0) finished = 1'b1;
                end
            end
            n_total++;
            if (duty_cycle !== DUTY_W'(cur))
                $display("FAIL %s duty: got %0d required %0d (boundary %0d, per_cnt %0d)",
                         tag, duty_cycle, cur, nb, tb_cnt);
            else n_pass++;
            if (!finished) begin
                n_total++;
                if (busy !== 1'b1 || done !== 1'b0)
                    $display("FAIL %s in_ramp: busy=%b done=%b required 1 0", tag, busy, done);
                else n_pass++;
            end
        end
        cmd_valid = 1'b0;

        n_total++;
        if (!finished) begin
            $display("FAIL %s timeout: ramp not finished, duty=%0d required %0d", tag, duty_cycle, tgt);
            m_duty = int'(duty_cycle);
        end else if (abort_req) begin
            if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1)
                $display("FAIL %s abort_end: done=%b busy=%b ready=%b required 0 0 1",
                         tag, done, busy, cmd_ready);
            else n_pass++;
            for (int i = 0; i < 3; i++) begin
                cyc();
                n_total++;
                if (done !== 1'b0 || duty_cycle !== '0)
                    $display("FAIL %s abort_quiet: done=%b duty=%0d required 0 0", tag, done, duty_cycle);
                else n_pass++;
            end
            m_duty = 0;
        end else begin
            if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b0)
                $display("FAIL %s done_pulse: done=%b busy=%b ready=%b required 1 0 0",
                         tag, done, busy, cmd_ready);
            else n_pass++;
            cyc();
            n_total++;
            if (done !== 1'b0 || cmd_ready !== 1'b1 || duty_cycle !== DUTY_W'(tgt))
                $display("FAIL %s after_done: done=%b ready=%b duty=%0d required 0 1 %0d",
                         tag, done, cmd_ready, duty_cycle, tgt);
            else n_pass++;
            m_duty = tgt;
        end
    endtask

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = '0;
        cmd_step   = '0;
        cmd_hold   = '0;
        abort      = 1'b0;
        #20;
        n_total++;
        if (duty_cycle !== '0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || period_end !== 1'b0)
            $display("FAIL reset_values: duty=%0d ready=%b busy=%b done=%b pend=%b required 0 1 0 0 0",
                     duty_cycle, cmd_ready, busy, done, period_end);
        else n_pass++;
        rst    = 1'b0;
        tb_cnt = 0;
        m_duty = 0;
        for (int i = 0; i < PERIOD - 1; i++) begin
            cyc();
            n_total++;
            if (period_end !== (tb_cnt == PERIOD - 1))
                $display("FAIL first_period_end: period_end=%b at clk %0d after reset, required %b",
                         period_end, tb_cnt, (tb_cnt == PERIOD - 1));
            else n_pass++;
        end
    endtask

    task automatic test_up_ramp();
        run_ramp(200, 50, 0, -1, "up_ramp");
    endtask

    task automatic test_down_ramp();
        run_ramp(30, 50, 1, -1, "down_ramp");
    endtask

    task automatic test_step_zero();
        run_ramp(33, 0, 0, -1, "step_zero");
    endtask

    task automatic test_equal_target();
        run_ramp(m_duty, 7, 2, -1, "equal_target");
    endtask

    task automatic test_abort_mid_ramp();
        run_ramp(0, 255, 0, -1, "to_zero");
        run_ramp(200, 50, 0, 1, "abort_mid");
    endtask

    task automatic test_abort_with_accept();
        int exp_d;
        bit bnd;
        bit seen;
        run_ramp(80, 80, 0, -1, "to_80");
        cmd_valid  = 1'b1;
        cmd_target = 8'd200;
        cmd_step   = 8'd10;
        cmd_hold   = '0;
        abort      = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        n_total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || duty_cycle !== 8'd80)
            $display("FAIL abort_accept_discard: ready=%b busy=%b done=%b duty=%0d required 1 0 0 80",
                     cmd_ready, busy, done, duty_cycle);
        else n_pass++;
        exp_d = 80;
        seen  = 1'b0;
        for (int i = 0; i < PERIOD + 4 && !seen; i++) begin
            bnd = (tb_cnt == PERIOD - 1);
            cyc();
            if (bnd) begin
                exp_d = 0;
                seen  = 1'b1;
            end
            n_total++;
            if (duty_cycle !== DUTY_W'(exp_d) || done !== 1'b0 || busy !== 1'b0)
                $display("FAIL abort_accept_drop: duty=%0d done=%b busy=%b required %0d 0 0",
                         duty_cycle, done, busy, exp_d);
            else n_pass++;
        end
        n_total++;
        if (!seen || cmd_ready !== 1'b1)
            $display("FAIL abort_accept_end: boundary_seen=%b ready=%b required 1 1", seen, cmd_ready);
        else n_pass++;
        m_duty = 0;
    endtask

    task automatic test_abort_idle();
        bit bnd;
        bit seen;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < PERIOD + 4; i++) begin
            bnd = (tb_cnt == PERIOD - 1);
            cyc();
            if (bnd) seen = 1'b1;
            n_total++;
            if (duty_cycle !== '0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
                $display("FAIL abort_idle: duty=%0d ready=%b busy=%b done=%b required 0 1 0 0",
                         duty_cycle, cmd_ready, busy, done);
            else n_pass++;
        end
        n_total++;
        if (!seen) $display("FAIL abort_idle_boundary: boundary_seen=%b required 1", seen);
        else n_pass++;
    endtask

    task automatic test_clamp();
        run_ramp(250, 100, 0, -1, "clamp");
    endtask

    task automatic test_random();
        int t;
        int s;
        int h;
        int a;
        for (int i = 0; i < 6; i++) begin
            t = $urandom_range(0, 255);
            s = $urandom_range(32, 255);
            h = $urandom_range(0, 1);
            a = ($urandom_range(0, 3) == 0) ? 0 : -1;
            run_ramp(t, s, h, a, $sformatf("random_%0d", i));
        end
    endtask

    task automatic test_async_reset();
        int tgt;
        int nb;
        int n;
        bit bnd;
        tgt = (m_duty < 128) ? 255 : 0;
        n   = 0;
        while (cmd_ready !== 1'b1 && n < 600) begin
            cyc();
            n++;
        end
        cmd_valid  = 1'b1;
        cmd_target = DUTY_W'(tgt);
        cmd_step   = 8'd40;
        cmd_hold   = '0;
        cyc();
        cmd_valid = 1'b0;
        nb = 0;
        n  = 0;
        while (nb < 2 && n < 3 * PERIOD) begin
            bnd = (tb_cnt == PERIOD - 1);
            cyc();
            n++;
            if (bnd) nb++;
        end
        for (int i = 0; i < 50; i++) cyc();
        n_total++;
        if (busy !== 1'b1 || duty_cycle === DUTY_W'(m_duty))
            $display("FAIL async_pre: busy=%b duty=%0d required busy 1 and duty moved from %0d",
                     busy, duty_cycle, m_duty);
        else n_pass++;
        #3;
        rst = 1'b1;
        #1;
        n_total++;
        if (duty_cycle !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || period_end !== 1'b0)
            $display("FAIL async_reset: duty=%0d busy=%b ready=%b done=%b pend=%b required 0 0 1 0 0",
                     duty_cycle, busy, cmd_ready, done, period_end);
        else n_pass++;
        @(posedge clk);
        #4;
        rst    = 1'b0;
        tb_cnt = 0;
        m_duty = 0;
        for (int i = 0; i < PERIOD; i++) begin
            cyc();
            n_total++;
            if (period_end !== (tb_cnt == PERIOD - 1) || duty_cycle !== '0)
                $display("FAIL post_reset: period_end=%b duty=%0d at clk %0d, required %b 0",
                         period_end, duty_cycle, tb_cnt, (tb_cnt == PERIOD - 1));
            else n_pass++;
        end
    endtask

    // -----------------------------------------------------------------------
    // Sequence and report
    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_up_ramp();
        test_down_ramp();
        test_step_zero();
        test_equal_target();
        test_abort_mid_ramp();
        test_abort_with_accept();
        test_abort_idle();
        test_clamp();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
